// File: rtl/push_clk_cnt_src_pkg.sv
// Shared constants and mode encoding for the push/clock counter source path.
package push_clk_pkg;

  localparam int unsigned WIDTH_DEF      = 8;
  localparam int unsigned DEB_CYCLES_DEF = 4;
  localparam int unsigned PRESCALE_DEF   = 16;

  typedef enum logic {
    MODE_PUSH = 1'b0,
    MODE_CLK  = 1'b1
  } mode_t;

  function automatic mode_t mode_toggle(input mode_t m);
    return (m == MODE_PUSH) ? MODE_CLK : MODE_PUSH;
  endfunction

endpackage

// File: rtl/push_clk_cnt_src_if.sv
// Button/run/clear inputs and count/select outputs of the counter source.
interface push_clk_cnt_src_if #(
  parameter int unsigned WIDTH = push_clk_pkg::WIDTH_DEF
);
  logic             push_btn;
  logic             mode_btn;
  logic             run;
  logic             clr;
  logic [WIDTH-1:0] push_cnt;
  logic [WIDTH-1:0] clk_cnt;
  logic             rw1;
  logic             rw0;
  logic             en;

  modport master (
    output push_btn, mode_btn, run, clr,
    input  push_cnt, clk_cnt, rw1, rw0, en
  );

  modport slave (
    input  push_btn, mode_btn, run, clr,
    output push_cnt, clk_cnt, rw1, rw0, en
  );
endinterface

// File: rtl/push_clk_cnt_src_btn_debounce.sv
// Two-flop synchroniser, run-length debounce and registered rise-edge pulse
// for one raw button.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = push_clk_pkg::DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q, sync_q;
  logic          db_q, db_d;
  logic          db_prev_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // A sample equal to db restarts the run; DEB_CYCLES differing samples flip db.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_q != db_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        db_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync_q    <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_i;
      sync_q    <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      press_q   <= db_q & ~db_prev_q;
      cnt_q     <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/push_clk_cnt_src.sv
// Counter source: debounced press counter, prescaled tick counter and the
// mutually exclusive rw1/rw0 select strobes for the output mux.
module push_clk_cnt_src
  import push_clk_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned PRESCALE   = PRESCALE_DEF
) (
  input logic               clk,
  input logic               rst,
  push_clk_cnt_src_if.slave bus
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic             push_press, mode_press;
  logic             en_q;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;
  logic [WIDTH-1:0] push_cnt_q, push_cnt_d;
  logic [WIDTH-1:0] clk_cnt_q, clk_cnt_d;
  mode_t            state_q;
  logic             rw1_q, rw0_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_push_db (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (bus.push_btn),
    .press_o (push_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_db (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (bus.mode_btn),
    .press_o (mode_press)
  );

  assign tick = en_q && (pre_q == PW'(PRESCALE - 1));

  // clr wins over a coincident press or tick.
  always_comb begin
    pre_d      = pre_q;
    push_cnt_d = push_cnt_q;
    clk_cnt_d  = clk_cnt_q;
    if (bus.clr) begin
      pre_d      = '0;
      push_cnt_d = '0;
      clk_cnt_d  = '0;
    end else begin
      if (en_q)       pre_d      = tick ? '0 : pre_q + 1'b1;
      if (push_press) push_cnt_d = push_cnt_q + 1'b1;
      if (tick)       clk_cnt_d  = clk_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= 1'b0;
      pre_q      <= '0;
      push_cnt_q <= '0;
      clk_cnt_q  <= '0;
    end else begin
      en_q       <= bus.run;
      pre_q      <= pre_d;
      push_cnt_q <= push_cnt_d;
      clk_cnt_q  <= clk_cnt_d;
    end
  end

  // Select strobes are decoded from the next state so they move with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MODE_PUSH;
      rw1_q   <= 1'b1;
      rw0_q   <= 1'b0;
    end else if (mode_press) begin
      state_q <= mode_toggle(state_q);
      rw1_q   <= (mode_toggle(state_q) == MODE_PUSH);
      rw0_q   <= (mode_toggle(state_q) == MODE_CLK);
    end
  end

  assign bus.push_cnt = push_cnt_q;
  assign bus.clk_cnt  = clk_cnt_q;
  assign bus.rw1      = rw1_q;
  assign bus.rw0      = rw0_q;
  assign bus.en       = en_q;

endmodule

// File: tb/tb_push_clk_cnt_src.sv
// Directed table-driven bench for push_clk_cnt_src at default parameters.
module tb_push_clk_cnt_src;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  push_clk_cnt_src_if #(.WIDTH(8)) bus ();

  push_clk_cnt_src #(
    .WIDTH      (8),
    .DEB_CYCLES (4),
    .PRESCALE   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic push;
    logic mode;
    logic run;
    logic clr;
    int   cycles;
    int   e_push;
    int   e_clk;
    logic e_rw1;
    logic e_en;
  } vec_t;

  vec_t vt[28];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input int ep, input int ec,
                         input logic erw1, input logic een);
    chk({tag, " push_cnt"}, int'(bus.push_cnt), ep);
    chk({tag, " clk_cnt"},  int'(bus.clk_cnt),  ec);
    chk({tag, " rw1"},      int'(bus.rw1),      int'(erw1));
    chk({tag, " rw0"},      int'(bus.rw0),      int'(!erw1));
    chk({tag, " en"},       int'(bus.en),       int'(een));
  endtask

  task automatic press_push();
    bus.push_btn = 1'b1;
    step(10);
    bus.push_btn = 1'b0;
    step(10);
  endtask

  task automatic press_mode();
    bus.mode_btn = 1'b1;
    step(10);
    bus.mode_btn = 1'b0;
    step(10);
  endtask

  // Prescaler must sit at 8 on entry: the raw push rise is placed so that
  // its press and the 8th enabled edge's tick land on the same edge.
  task automatic aligned(input string tag, input bit do_clr,
                         input int p0, input int c0, input int p1, input int c1);
    bus.run = 1'b1;
    step(1);
    bus.push_btn = 1'b1;
    step(7);
    chk({tag, " pre push_cnt"}, int'(bus.push_cnt), p0);
    chk({tag, " pre clk_cnt"},  int'(bus.clk_cnt),  c0);
    bus.run = 1'b0;
    bus.clr = do_clr;
    step(1);
    chk({tag, " push_cnt"}, int'(bus.push_cnt), p1);
    chk({tag, " clk_cnt"},  int'(bus.clk_cnt),  c1);
    chk({tag, " rw1"},      int'(bus.rw1),      1);
    bus.clr      = 1'b0;
    bus.push_btn = 1'b0;
    step(20);
  endtask

  always @(negedge clk) begin
    if (mon_en) chk("rw1/rw0 exclusive", int'(bus.rw1 ^ bus.rw0), 1);
  end

  initial begin
    //         push mode run clr cyc  push clk rw1 en
    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,  20, 0,  0, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0,   6, 0,  0, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0,   1, 0,  0, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0,   1, 1,  0, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0,  18, 1,  0, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0,  20, 1,  0, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b0,   3, 1,  0, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0,  20, 1,  0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0,   6, 1,  0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0,   1, 1,  0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0,   1, 1,  0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0,  20, 1,  0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b1, 1'b0,   1, 1,  0, 1'b0, 1'b1};
    vt[13] = '{1'b0, 1'b0, 1'b1, 1'b0,  15, 1,  0, 1'b0, 1'b1};
    vt[14] = '{1'b0, 1'b0, 1'b1, 1'b0,   1, 1,  1, 1'b0, 1'b1};
    vt[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 143, 1,  9, 1'b0, 1'b1};
    vt[16] = '{1'b0, 1'b0, 1'b0, 1'b0,   1, 1, 10, 1'b0, 1'b0};
    vt[17] = '{1'b0, 1'b0, 1'b0, 1'b0,  30, 1, 10, 1'b0, 1'b0};
    vt[18] = '{1'b0, 1'b0, 1'b1, 1'b0,   9, 1, 10, 1'b0, 1'b1};
    vt[19] = '{1'b0, 1'b0, 1'b0, 1'b0,  20, 1, 10, 1'b0, 1'b0};
    vt[20] = '{1'b0, 1'b0, 1'b1, 1'b0,   7, 1, 10, 1'b0, 1'b1};
    vt[21] = '{1'b0, 1'b0, 1'b1, 1'b0,   1, 1, 11, 1'b0, 1'b1};
    vt[22] = '{1'b0, 1'b0, 1'b0, 1'b0,   5, 1, 11, 1'b0, 1'b0};
    vt[23] = '{1'b0, 1'b0, 1'b0, 1'b1,   1, 0,  0, 1'b0, 1'b0};
    vt[24] = '{1'b0, 1'b1, 1'b0, 1'b0,   7, 0,  0, 1'b0, 1'b0};
    vt[25] = '{1'b0, 1'b1, 1'b0, 1'b0,   1, 0,  0, 1'b1, 1'b0};
    vt[26] = '{1'b0, 1'b0, 1'b0, 1'b0,  20, 0,  0, 1'b1, 1'b0};
    vt[27] = '{1'b0, 1'b0, 1'b0, 1'b0,   5, 0,  0, 1'b1, 1'b0};

    bus.push_btn = 1'b0;
    bus.mode_btn = 1'b0;
    bus.run      = 1'b0;
    bus.clr      = 1'b0;
    rst          = 1'b1;
    step(3);
    rst    = 1'b0;
    mon_en = 1'b1;
    chk_all("reset", 0, 0, 1'b1, 1'b0);

    for (int i = 0; i < 28; i++) begin
      bus.push_btn = vt[i].push;
      bus.mode_btn = vt[i].mode;
      bus.run      = vt[i].run;
      bus.clr      = vt[i].clr;
      step(vt[i].cycles);
      chk_all($sformatf("vec%0d", i), vt[i].e_push, vt[i].e_clk, vt[i].e_rw1, vt[i].e_en);
    end
    bus.clr = 1'b0;

    for (int i = 0; i < 255; i++) press_push();
    chk("255 presses", int'(bus.push_cnt), 255);
    press_push();
    chk("256 presses wrap", int'(bus.push_cnt), 0);
    press_push();
    chk("257 presses", int'(bus.push_cnt), 1);

    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    chk("clr push_cnt", int'(bus.push_cnt), 0);
    for (int i = 0; i < 5; i++) press_push();
    bus.run = 1'b1;
    step(152);
    bus.run = 1'b0;
    step(5);
    chk("setup push_cnt", int'(bus.push_cnt), 5);
    chk("setup clk_cnt",  int'(bus.clk_cnt),  9);
    aligned("clr vs press+tick", 1'b1, 5, 9, 0, 0);

    bus.run = 1'b1;
    step(8);
    bus.run = 1'b0;
    step(5);
    aligned("press+tick", 1'b0, 0, 0, 1, 1);

    press_mode();
    chk("mode before rst rw1", int'(bus.rw1), 0);
    bus.push_btn = 1'b1;
    step(4);
    bus.push_btn = 1'b0;
    rst          = 1'b1;
    step(1);
    rst = 1'b0;
    chk_all("mid-debounce rst", 0, 0, 1'b1, 1'b0);
    step(30);
    chk("no late increment", int'(bus.push_cnt), 0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
